// File: rtl/ariane_pkg.sv
// Shared core types used by the instruction window and its neighbours.
//   NR_SB_ENTRIES    default depth of the scoreboard window
//   TRANS_ID_BITS    width of a slot index (transaction id)
//   fu_t             functional-unit selector carried with each instruction
//   exception        exception record; 'valid' marks a raised exception
//   scoreboard_entry one in-flight instruction as tracked by the scoreboard
//   onehot_rd        register-number to clobber-mask helper (x0 never reported)
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef enum logic [3:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;     // result has been written back
    exception                 ex;
  } scoreboard_entry;

  // x0 is hard-wired to zero, so it never counts as a pending write.
  function automatic logic [31:0] onehot_rd(input logic [4:0] rd);
    logic [31:0] mask;
    mask     = 32'b0;
    mask[rd] = 1'b1;
    mask[0]  = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/scoreboard.sv
// In-order instruction window between decode and issue/execute/commit.
// Entries live in a circular buffer in program order. Three pointers walk it:
// alloc_ptr (next free slot), issue_ptr (oldest un-issued), commit_ptr (head).
//
// Optional build macro: SCOREBOARD_WB_BYPASS_EN
//   defined   - a writeback aimed at the in-flight head is presented to commit
//               in the same cycle (0-cycle writeback-to-commit).
//   undefined - writebacks reach commit through the slot register only (1 cycle).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i                      drop every entry; beats alloc/issue/wb/commit
//   full_o                       all slots occupied
//   decoded_instr_i/_valid_i     entry offered by decode
//   decoded_instr_ack_o          entry taken this cycle
//   issue_instr_o/_trans_id_o    oldest un-issued entry and its slot index
//   issue_instr_valid_o          an un-issued entry is available
//   issue_ack_i                  issue consumed the offered entry
//   wb_valid_i/_trans_id_i       FU writeback strobe and target slot
//   wb_data_i, wb_ex_i           writeback result and exception
//   commit_instr_o/_valid_o      head entry, valid once its result is in
//   commit_ack_i                 commit retires the head
//   rd_clobber_o                 bit r set iff a live entry writes register r
//
// Handshakes: every channel transfers on a cycle where its valid and its
// ack/ready are both high. The producer may hold valid without waiting for the
// ack; an ack seen while valid is low is ignored. decoded_instr_ack_o is itself
// the transfer indication for the decode channel (valid & ~full & ~flush).
module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES,
  localparam int unsigned IDX_W = $clog2(NR_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  output logic              full_o,
  input  scoreboard_entry   decoded_instr_i,
  input  logic              decoded_instr_valid_i,
  output logic              decoded_instr_ack_o,
  output scoreboard_entry   issue_instr_o,
  output logic [IDX_W-1:0]  issue_trans_id_o,
  output logic              issue_instr_valid_o,
  input  logic              issue_ack_i,
  input  logic              wb_valid_i,
  input  logic [IDX_W-1:0]  wb_trans_id_i,
  input  logic [63:0]       wb_data_i,
  input  exception          wb_ex_i,
  output scoreboard_entry   commit_instr_o,
  output logic              commit_valid_o,
  input  logic              commit_ack_i,
  output logic [31:0]       rd_clobber_o
);

  scoreboard_entry [NR_ENTRIES-1:0] mem;
  logic [NR_ENTRIES-1:0] in_flight;

  logic [IDX_W-1:0] commit_ptr;
  logic [IDX_W-1:0] issue_ptr;
  logic [IDX_W-1:0] alloc_ptr;
  logic [IDX_W:0]   count;

  logic alloc_fire;
  logic issue_fire;
  logic commit_fire;
  logic wb_hits_head;

  assign full_o              = (count == (IDX_W+1)'(NR_ENTRIES));
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign alloc_fire          = decoded_instr_ack_o;

  // When the window is full, alloc_ptr has wrapped onto commit_ptr, so pointer
  // equality alone cannot distinguish "nothing to issue" from "everything left
  // to issue"; the head's in_flight bit breaks the tie.
  assign issue_instr_valid_o = (issue_ptr != alloc_ptr) |
                               (full_o & (issue_ptr == commit_ptr) & ~in_flight[issue_ptr]);
  assign issue_fire          = issue_ack_i & issue_instr_valid_o;
  assign issue_trans_id_o    = issue_ptr;

  always_comb begin
    issue_instr_o          = mem[issue_ptr];
    issue_instr_o.trans_id = TRANS_ID_BITS'(issue_ptr);
  end

  assign wb_hits_head = wb_valid_i & (wb_trans_id_i == commit_ptr) & in_flight[commit_ptr];

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign commit_valid_o = (count != '0) & (mem[commit_ptr].valid | wb_hits_head);

  always_comb begin
    commit_instr_o = mem[commit_ptr];
    if (wb_hits_head) begin
      commit_instr_o.result = wb_data_i;
      commit_instr_o.ex     = wb_ex_i;
      commit_instr_o.valid  = 1'b1;
    end
  end
`else
  assign commit_valid_o = (count != '0) & mem[commit_ptr].valid;
  assign commit_instr_o = mem[commit_ptr];

  // Only the bypass build consumes the head-match term.
  logic unused_wb_hits_head;
  assign unused_wb_hits_head = wb_hits_head;
`endif

  assign commit_fire = commit_ack_i & commit_valid_o;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    rd_clobber_o = 32'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if ({1'b0, IDX_W'(i) - commit_ptr} < count) begin
        rd_clobber_o = rd_clobber_o | onehot_rd(mem[i].rd);
      end
    end
  end

  // Update order inside the else branch matters: a commit of the same slot as a
  // writeback (bypass case) must win, so commit's clears come last.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      commit_ptr <= '0;
      issue_ptr  <= '0;
      alloc_ptr  <= '0;
      count      <= '0;
      in_flight  <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem[i].valid    <= 1'b0;
        mem[i].ex.valid <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        mem[alloc_ptr]          <= decoded_instr_i;
        mem[alloc_ptr].trans_id <= TRANS_ID_BITS'(alloc_ptr);
        mem[alloc_ptr].valid    <= 1'b0;
        mem[alloc_ptr].ex.valid <= 1'b0;
        in_flight[alloc_ptr]    <= 1'b0;
        alloc_ptr               <= alloc_ptr + 1'b1;
      end

      if (issue_fire) begin
        in_flight[issue_ptr] <= 1'b1;
        issue_ptr            <= issue_ptr + 1'b1;
      end

      // Stale or spurious writebacks to slots that were never issued are dropped.
      if (wb_valid_i && in_flight[wb_trans_id_i]) begin
        mem[wb_trans_id_i].result <= wb_data_i;
        mem[wb_trans_id_i].valid  <= 1'b1;
        mem[wb_trans_id_i].ex     <= wb_ex_i;
      end

      if (commit_fire) begin
        mem[commit_ptr].valid <= 1'b0;
        in_flight[commit_ptr] <= 1'b0;
        commit_ptr            <= commit_ptr + 1'b1;
      end

      count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard. Expected commits are queued when decode
// hands over an entry; a monitor pops and compares on every commit transfer.
// Inputs change 1 time unit after the rising edge, outputs are read on the
// falling edge.
module tb_scoreboard;
  import ariane_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  localparam int W = 78;  // {rd, result, ex.valid, ex.cause[7:0]}

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            full_o;
  scoreboard_entry decoded_instr_i;
  logic            decoded_instr_valid_i;
  logic            decoded_instr_ack_o;
  scoreboard_entry issue_instr_o;
  logic [2:0]      issue_trans_id_o;
  logic            issue_instr_valid_o;
  logic            issue_ack_i;
  logic            wb_valid_i;
  logic [2:0]      wb_trans_id_i;
  logic [63:0]     wb_data_i;
  exception        wb_ex_i;
  scoreboard_entry commit_instr_o;
  logic            commit_valid_o;
  logic            commit_ack_i;
  logic [31:0]     rd_clobber_o;

  scoreboard dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .full_o                (full_o),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_trans_id_o      (issue_trans_id_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .issue_ack_i           (issue_ack_i),
    .wb_valid_i            (wb_valid_i),
    .wb_trans_id_i         (wb_trans_id_i),
    .wb_data_i             (wb_data_i),
    .wb_ex_i               (wb_ex_i),
    .commit_instr_o        (commit_instr_o),
    .commit_valid_o        (commit_valid_o),
    .commit_ack_i          (commit_ack_i),
    .rd_clobber_o          (rd_clobber_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp     = 0;
  int n_bad     = 0;
  int n_commit  = 0;
  int n_pushed  = 0;
  int n_flushed = 0;

  // Bench-side model of the slot each accepted entry lands in, and its planned result.
  logic [2:0]  m_alloc;
  logic [63:0] plan_res   [8];
  logic        plan_exv   [8];
  logic [7:0]  plan_cause [8];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_i && !flush_i && commit_valid_o && commit_ack_i) begin
      n_commit++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL commit_extra: got rd=%0d result=%0h, expected no commit",
                 commit_instr_o.rd, commit_instr_o.result);
      end else begin
        chk("commit_entry",
            {2'b0, commit_instr_o.rd, commit_instr_o.result,
             commit_instr_o.ex.valid, commit_instr_o.ex.cause[7:0]},
            {2'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sync();
    decoded_instr_valid_i = 1'b0;
    issue_ack_i           = 1'b0;
    wb_valid_i            = 1'b0;
    flush_i               = 1'b0;
  endtask

  function automatic scoreboard_entry mk(input logic [4:0] rd);
    scoreboard_entry e;
    e     = '0;
    e.pc  = 64'h8000_0000 + {59'b0, rd};
    e.fu  = FU_ALU;
    e.rs1 = 5'd1;
    e.rs2 = 5'd2;
    e.rd  = rd;
    return e;
  endfunction

  task automatic alloc(input logic [4:0] rd, input logic [63:0] res,
                       input logic exv, input logic [7:0] cause, input logic exp_ack);
    decoded_instr_i       = mk(rd);
    decoded_instr_valid_i = 1'b1;
    @(negedge clk);
    chk("alloc_ack", decoded_instr_ack_o, exp_ack);
    if (exp_ack) begin
      plan_res[m_alloc]   = res;
      plan_exv[m_alloc]   = exv;
      plan_cause[m_alloc] = cause;
      exp_q.push_back({rd, res, exv, cause});
      n_pushed++;
      m_alloc++;
    end
    tick();
  endtask

  task automatic do_issue(input logic [2:0] exp_id);
    issue_ack_i = 1'b1;
    @(negedge clk);
    chk("issue_valid", issue_instr_valid_o, 1'b1);
    chk("issue_trans_id", issue_trans_id_o, exp_id);
    tick();
  endtask

  // exp_cv < 0 skips the same-cycle commit_valid check.
  task automatic do_wb(input logic [2:0] id, input int exp_cv);
    wb_valid_i       = 1'b1;
    wb_trans_id_i    = id;
    wb_data_i        = plan_res[id];
    wb_ex_i          = '0;
    wb_ex_i.valid    = plan_exv[id];
    wb_ex_i.cause    = {56'b0, plan_cause[id]};
    @(negedge clk);
    if (exp_cv >= 0) chk("wb_cycle_commit_valid", commit_valid_o, exp_cv[0]);
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i   = 1'b0;
    m_alloc = 3'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i                 = 1'b1;
    flush_i               = 1'b0;
    decoded_instr_i       = '0;
    decoded_instr_valid_i = 1'b0;
    issue_ack_i           = 1'b0;
    wb_valid_i            = 1'b0;
    wb_trans_id_i         = '0;
    wb_data_i             = '0;
    wb_ex_i               = '0;
    commit_ack_i          = 1'b0;
    m_alloc               = 3'd0;
    do_reset();

    // 1: reset state, single alloc, issue latency and clobber mask
    @(negedge clk);
    chk("rst_full", full_o, 1'b0);
    chk("rst_issue_valid", issue_instr_valid_o, 1'b0);
    chk("rst_commit_valid", commit_valid_o, 1'b0);
    chk("rst_clobber", rd_clobber_o, 32'h0);
    sync();
    commit_ack_i = 1'b1;
    alloc(5'd5, 64'h55, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    chk("t1_issue_valid", issue_instr_valid_o, 1'b1);
    chk("t1_trans_id", issue_trans_id_o, 3'd0);
    chk("t1_issue_rd", issue_instr_o.rd, 5'd5);
    chk("t1_clobber", rd_clobber_o, 32'h20);
    sync();
    do_issue(3'd0);
    do_wb(3'd0, BYP);
    wait_drain();

    // 2: fill to full, refused alloc, commit does not free space same cycle
    commit_ack_i = 1'b0;
    for (int k = 0; k < 8; k++) alloc(5'(k + 1), 64'h200 + 64'(k), 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    chk("t2_full", full_o, 1'b1);
    chk("t2_clobber", rd_clobber_o, 32'h1FE);
    sync();
    alloc(5'd20, 64'hDEAD, 1'b0, 8'd0, 1'b0);
    do_issue(3'd1);
    do_wb(3'd1, BYP);
    commit_ack_i          = 1'b1;
    decoded_instr_i       = mk(5'd21);
    decoded_instr_valid_i = 1'b1;
    @(negedge clk);
    chk("t2_commit_valid", commit_valid_o, 1'b1);
    chk("t2_commit_alloc_ack", decoded_instr_ack_o, 1'b0);
    chk("t2_full_during_commit", full_o, 1'b1);
    tick();
    @(negedge clk);
    chk("t2_full_after_commit", full_o, 1'b0);
    sync();
    alloc(5'd9, 64'h209, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    chk("t2_full_again", full_o, 1'b1);
    chk("t2_clobber_wrap", rd_clobber_o, 32'h3FC);
    sync();
    for (int k = 0; k < 8; k++) do_issue(3'((2 + k) % 8));
    for (int k = 0; k < 8; k++) do_wb(3'((2 + k) % 8), -1);
    wait_drain();

    // 3: out-of-order writeback, in-order commit
    do_reset();
    alloc(5'd3, 64'h11, 1'b0, 8'd0, 1'b1);
    alloc(5'd4, 64'hAB, 1'b0, 8'd0, 1'b1);
    do_issue(3'd0);
    do_issue(3'd1);
    do_wb(3'd1, 0);
    @(negedge clk);
    chk("t3_head_not_ready", commit_valid_o, 1'b0);
    sync();
    do_wb(3'd0, BYP);
    wait_drain();

    // 4: exception carried from writeback to commit
    alloc(5'd6, 64'h0, 1'b1, 8'd2, 1'b1);
    do_issue(3'd2);
    do_wb(3'd2, BYP);
    wait_drain();

    // 5: flush beats a same-cycle alloc and writeback
    commit_ack_i = 1'b0;
    alloc(5'd0,  64'h500, 1'b0, 8'd0, 1'b1);
    alloc(5'd9,  64'h501, 1'b0, 8'd0, 1'b1);
    alloc(5'd10, 64'h502, 1'b0, 8'd0, 1'b1);
    alloc(5'd11, 64'h503, 1'b0, 8'd0, 1'b1);
    alloc(5'd12, 64'h504, 1'b0, 8'd0, 1'b1);
    do_issue(3'd3);
    do_issue(3'd4);
    @(negedge clk);
    chk("t5_clobber_no_x0", rd_clobber_o, 32'h1E00);
    sync();
    flush_i               = 1'b1;
    decoded_instr_i       = mk(5'd13);
    decoded_instr_valid_i = 1'b1;
    wb_valid_i            = 1'b1;
    wb_trans_id_i         = 3'd3;
    wb_data_i             = 64'h503;
    wb_ex_i               = '0;
    @(negedge clk);
    chk("t5_flush_ack", decoded_instr_ack_o, 1'b0);
    tick();
    n_flushed += exp_q.size();
    exp_q.delete();
    m_alloc = 3'd0;
    @(negedge clk);
    chk("t5_full", full_o, 1'b0);
    chk("t5_clobber", rd_clobber_o, 32'h0);
    chk("t5_issue_valid", issue_instr_valid_o, 1'b0);
    chk("t5_commit_valid", commit_valid_o, 1'b0);
    sync();

    // 6: pointer wrap over 20 single-entry rounds
    commit_ack_i = 1'b1;
    for (int r = 0; r < 20; r++) begin
      alloc(5'((r % 31) + 1), 64'h1000 + 64'(r), 1'b0, 8'd0, 1'b1);
      do_issue(3'(r % 8));
      do_wb(3'(r % 8), BYP);
      tick();
    end
    wait_drain();

    chk("total_commits", n_commit, n_pushed - n_flushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
